// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timebase slice.
//   sw_state_t : run-control FSM states
//   SEC_MOD    : seconds modulus, SEC_W its field width
//   cnt_w()    : width of a counter that spans 0..modulus-1 (never below 1)
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } sw_state_t;

    localparam int unsigned SEC_MOD = 60;
    localparam int unsigned SEC_W   = 6;

    function automatic int unsigned cnt_w(input int unsigned modulus);
        return (modulus <= 2) ? 1 : $clog2(modulus);
    endfunction

endpackage

// File: rtl/stopwatch_timebase_if.sv
// Control pulses in, time fields out, for the stopwatch timebase.
//   master : button front-end / display side (drives start_stop, clear, lap)
//   slave  : stopwatch_timebase (drives tick, time fields, status, lap capture)
// Parameters TICK_HZ / MAX_MIN must match the attached stopwatch_timebase.
interface stopwatch_timebase_if
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_HZ = 100,
    parameter int unsigned MAX_MIN = 60
);
    localparam int unsigned FRAC_W = cnt_w(TICK_HZ);
    localparam int unsigned MIN_W  = cnt_w(MAX_MIN);

    logic              start_stop;
    logic              clear;
    logic              lap;
    logic              tick;
    logic [FRAC_W-1:0] frac;
    logic [SEC_W-1:0]  sec;
    logic [MIN_W-1:0]  min;
    logic              running;
    logic              ovf;
    logic [FRAC_W-1:0] lap_frac;
    logic [SEC_W-1:0]  lap_sec;
    logic [MIN_W-1:0]  lap_min;
    logic              lap_valid;

    modport master (
        output start_stop, clear, lap,
        input  tick, frac, sec, min, running, ovf,
        input  lap_frac, lap_sec, lap_min, lap_valid
    );

    modport slave (
        input  start_stop, clear, lap,
        output tick, frac, sec, min, running, ovf,
        output lap_frac, lap_sec, lap_min, lap_valid
    );

endinterface

// File: rtl/tick_prescaler.sv
// Divides clk by DIV while enabled; strobe is high on the last cycle of each interval.
//   clk, n_rst : clock, asynchronous active-high reset
//   en         : count enable (held value when low, so an interval can be resumed)
//   clr        : zero the counter; overrides en and suppresses strobe
//   strobe     : combinational, high when cyc == DIV-1 and en
module tick_prescaler #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic n_rst,
    input  logic en,
    input  logic clr,
    output logic strobe
);
    localparam int unsigned       CYC_W    = $clog2(DIV);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(DIV - 1);

    logic [CYC_W-1:0] cyc_q;

    assign strobe = en && !clr && (cyc_q == CYC_LAST);

    // Interval counter; wraps to 0 on the strobe cycle
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            cyc_q <= '0;
        end else if (clr) begin
            cyc_q <= '0;
        end else if (en) begin
            cyc_q <= strobe ? '0 : cyc_q + CYC_W'(1);
        end
    end

endmodule

// File: rtl/stopwatch_timebase.sv
// Stopwatch core: divides clk to a TICK_HZ timebase and counts frac/sec/min.
//   clk   : system clock
//   n_rst : asynchronous reset, active-high
//   bus   : stopwatch_timebase_if.slave
//           in : start_stop (toggle run/pause), clear (back to IDLE, zero), lap
//           out: tick, frac, sec, min, running, ovf (sticky wrap),
//                lap_frac, lap_sec, lap_min, lap_valid
// Optional lap capture is built when STOPWATCH_LAP_EN is defined; otherwise
// lap is ignored and the lap outputs are tied to 0.
module stopwatch_timebase
    import stopwatch_pkg::*;
#(
    parameter int unsigned FREQUENCY = 10_000_000,
    parameter int unsigned TICK_HZ   = 100,
    parameter int unsigned MAX_MIN   = 60
) (
    input  logic                clk,
    input  logic                n_rst,
    stopwatch_timebase_if.slave bus
);
    localparam int unsigned       DIV       = FREQUENCY / TICK_HZ;
    localparam int unsigned       FRAC_W    = cnt_w(TICK_HZ);
    localparam int unsigned       MIN_W     = cnt_w(MAX_MIN);
    localparam logic [FRAC_W-1:0] FRAC_LAST = FRAC_W'(TICK_HZ - 1);
    localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_MOD - 1);
    localparam logic [MIN_W-1:0]  MIN_LAST  = MIN_W'(MAX_MIN - 1);

    if (((FREQUENCY % TICK_HZ) != 0) || (DIV < 2)) begin : g_cfg_err
        $error("stopwatch_timebase: FREQUENCY must be a multiple of TICK_HZ with DIV >= 2");
    end

    sw_state_t         state_q, state_d;
    logic              run_en;
    logic              strobe;
    logic              tick_q;
    logic              running_q;
    logic              ovf_q;
    logic [FRAC_W-1:0] frac_q;
    logic [SEC_W-1:0]  sec_q;
    logic [MIN_W-1:0]  min_q;

    // Run-control state register
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: clear dominates start_stop
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = IDLE;
        end else if (bus.start_stop) begin
            case (state_q)
                IDLE:    state_d = RUNNING;
                RUNNING: state_d = PAUSED;
                PAUSED:  state_d = RUNNING;
                default: state_d = IDLE;
            endcase
        end
    end

    assign run_en = (state_q == RUNNING);

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk    (clk),
        .n_rst  (n_rst),
        .en     (run_en),
        .clr    (bus.clear),
        .strobe (strobe)
    );

    // Time counters with cascaded carries; ovf is sticky until clear/reset
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            ovf_q     <= 1'b0;
            frac_q    <= '0;
            sec_q     <= '0;
            min_q     <= '0;
        end else if (bus.clear) begin
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            ovf_q     <= 1'b0;
            frac_q    <= '0;
            sec_q     <= '0;
            min_q     <= '0;
        end else begin
            tick_q    <= strobe;
            running_q <= (state_d == RUNNING);
            if (strobe) begin
                if (frac_q == FRAC_LAST) begin
                    frac_q <= '0;
                    if (sec_q == SEC_LAST) begin
                        sec_q <= '0;
                        if (min_q == MIN_LAST) begin
                            min_q <= '0;
                            ovf_q <= 1'b1;
                        end else begin
                            min_q <= min_q + MIN_W'(1);
                        end
                    end else begin
                        sec_q <= sec_q + SEC_W'(1);
                    end
                end else begin
                    frac_q <= frac_q + FRAC_W'(1);
                end
            end
        end
    end

    assign bus.tick    = tick_q;
    assign bus.running = running_q;
    assign bus.ovf     = ovf_q;
    assign bus.frac    = frac_q;
    assign bus.sec     = sec_q;
    assign bus.min     = min_q;

`ifdef STOPWATCH_LAP_EN
    logic [FRAC_W-1:0] lap_frac_q;
    logic [SEC_W-1:0]  lap_sec_q;
    logic [MIN_W-1:0]  lap_min_q;
    logic              lap_valid_q;

    // Capture reads the counters before this cycle's increment lands
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            lap_frac_q  <= '0;
            lap_sec_q   <= '0;
            lap_min_q   <= '0;
            lap_valid_q <= 1'b0;
        end else if (bus.clear) begin
            lap_frac_q  <= '0;
            lap_sec_q   <= '0;
            lap_min_q   <= '0;
            lap_valid_q <= 1'b0;
        end else if (bus.lap && run_en) begin
            lap_frac_q  <= frac_q;
            lap_sec_q   <= sec_q;
            lap_min_q   <= min_q;
            lap_valid_q <= 1'b1;
        end
    end

    assign bus.lap_frac  = lap_frac_q;
    assign bus.lap_sec   = lap_sec_q;
    assign bus.lap_min   = lap_min_q;
    assign bus.lap_valid = lap_valid_q;
`else
    logic unused_lap;
    assign unused_lap    = bus.lap;
    assign bus.lap_frac  = '0;
    assign bus.lap_sec   = '0;
    assign bus.lap_min   = '0;
    assign bus.lap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Directed bench for stopwatch_timebase. Main DUT: FREQUENCY=1000, TICK_HZ=100
// (DIV=10), MAX_MIN=2. A second instance with DIV=2 reaches the full wrap quickly.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_stopwatch_timebase;

    logic clk;
    logic n_rst;
    int   n_cmp;
    int   n_fail;

    stopwatch_timebase_if #(.TICK_HZ(100), .MAX_MIN(2)) sw_if ();
    stopwatch_timebase_if #(.TICK_HZ(100), .MAX_MIN(2)) f_if ();

    stopwatch_timebase #(
        .FREQUENCY (1000),
        .TICK_HZ   (100),
        .MAX_MIN   (2)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (sw_if)
    );

    stopwatch_timebase #(
        .FREQUENCY (200),
        .TICK_HZ   (100),
        .MAX_MIN   (2)
    ) dut_fast (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (f_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        int ticks;
        ticks = 0;
        n_rst = 1'b1;
        sw_if.start_stop = 1'b0; sw_if.clear = 1'b0; sw_if.lap = 1'b0;
        f_if.start_stop  = 1'b0; f_if.clear  = 1'b0; f_if.lap  = 1'b0;
        repeat (3) @(negedge clk);
        n_rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sw_if.tick) ticks++;
        end
        n_cmp++; if (ticks != 0) begin n_fail++; $display("FAIL reset.ticks: got %0d expected 0", ticks); end
        n_cmp++; if (sw_if.frac !== 7'd0) begin n_fail++; $display("FAIL reset.frac: got %0d expected 0", sw_if.frac); end
        n_cmp++; if (sw_if.sec !== 6'd0) begin n_fail++; $display("FAIL reset.sec: got %0d expected 0", sw_if.sec); end
        n_cmp++; if (sw_if.min !== 1'b0) begin n_fail++; $display("FAIL reset.min: got %0d expected 0", sw_if.min); end
        n_cmp++; if (sw_if.running !== 1'b0) begin n_fail++; $display("FAIL reset.running: got %0d expected 0", sw_if.running); end
        n_cmp++; if (sw_if.ovf !== 1'b0) begin n_fail++; $display("FAIL reset.ovf: got %0d expected 0", sw_if.ovf); end
        n_cmp++; if (sw_if.lap_valid !== 1'b0) begin n_fail++; $display("FAIL reset.lap_valid: got %0d expected 0", sw_if.lap_valid); end
    endtask

    task automatic test_run();
        int ticks;
        int bad_pos;
        ticks = 0;
        bad_pos = 0;
        sw_if.start_stop = 1'b1;
        @(negedge clk);
        sw_if.start_stop = 1'b0;
        n_cmp++; if (sw_if.running !== 1'b1) begin n_fail++; $display("FAIL run.running_early: got %0d expected 1", sw_if.running); end
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (sw_if.tick) ticks++;
            if (sw_if.tick !== ((i % 10) == 0)) bad_pos++;
        end
        n_cmp++; if (ticks != 10) begin n_fail++; $display("FAIL run.ticks: got %0d expected 10", ticks); end
        n_cmp++; if (bad_pos != 0) begin n_fail++; $display("FAIL run.spacing: got %0d misplaced expected 0", bad_pos); end
        n_cmp++; if (sw_if.frac !== 7'd10) begin n_fail++; $display("FAIL run.frac: got %0d expected 10", sw_if.frac); end
        n_cmp++; if (sw_if.sec !== 6'd0) begin n_fail++; $display("FAIL run.sec: got %0d expected 0", sw_if.sec); end
    endtask

    task automatic test_pause_resume();
        int ticks;
        int first;
        ticks = 0;
        first = -1;
        sw_if.clear = 1'b1;
        @(negedge clk);
        sw_if.clear = 1'b0;
        sw_if.start_stop = 1'b1;
        @(negedge clk);
        sw_if.start_stop = 1'b0;
        repeat (24) @(negedge clk);
        sw_if.start_stop = 1'b1;
        @(negedge clk);
        sw_if.start_stop = 1'b0;
        n_cmp++; if (sw_if.frac !== 7'd2) begin n_fail++; $display("FAIL pause.frac: got %0d expected 2", sw_if.frac); end
        n_cmp++; if (sw_if.running !== 1'b0) begin n_fail++; $display("FAIL pause.running: got %0d expected 0", sw_if.running); end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sw_if.tick) ticks++;
        end
        n_cmp++; if (ticks != 0) begin n_fail++; $display("FAIL pause.ticks: got %0d expected 0", ticks); end
        n_cmp++; if (sw_if.frac !== 7'd2) begin n_fail++; $display("FAIL pause.hold: got %0d expected 2", sw_if.frac); end
        sw_if.start_stop = 1'b1;
        @(negedge clk);
        sw_if.start_stop = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (sw_if.tick && first < 0) first = i;
            if (first == i) break;
        end
        n_cmp++; if (first != 5) begin n_fail++; $display("FAIL resume.first_tick: got %0d expected 5", first); end
        n_cmp++; if (sw_if.frac !== 7'd3) begin n_fail++; $display("FAIL resume.frac: got %0d expected 3", sw_if.frac); end
        n_cmp++; if (sw_if.running !== 1'b1) begin n_fail++; $display("FAIL resume.running: got %0d expected 1", sw_if.running); end
    endtask

    task automatic test_wrap();
        f_if.start_stop = 1'b1;
        @(negedge clk);
        f_if.start_stop = 1'b0;
        repeat (23998) @(negedge clk);
        n_cmp++; if (f_if.min !== 1'b1) begin n_fail++; $display("FAIL wrap.pre_min: got %0d expected 1", f_if.min); end
        n_cmp++; if (f_if.sec !== 6'd59) begin n_fail++; $display("FAIL wrap.pre_sec: got %0d expected 59", f_if.sec); end
        n_cmp++; if (f_if.frac !== 7'd99) begin n_fail++; $display("FAIL wrap.pre_frac: got %0d expected 99", f_if.frac); end
        n_cmp++; if (f_if.ovf !== 1'b0) begin n_fail++; $display("FAIL wrap.pre_ovf: got %0d expected 0", f_if.ovf); end
        repeat (2) @(negedge clk);
        n_cmp++; if (f_if.tick !== 1'b1) begin n_fail++; $display("FAIL wrap.tick: got %0d expected 1", f_if.tick); end
        n_cmp++; if ({f_if.min, f_if.sec, f_if.frac} !== 14'd0) begin n_fail++; $display("FAIL wrap.fields: got %0d:%0d.%0d expected 0:0.0", f_if.min, f_if.sec, f_if.frac); end
        n_cmp++; if (f_if.ovf !== 1'b1) begin n_fail++; $display("FAIL wrap.ovf: got %0d expected 1", f_if.ovf); end
        n_cmp++; if (f_if.running !== 1'b1) begin n_fail++; $display("FAIL wrap.running: got %0d expected 1", f_if.running); end
        repeat (2) @(negedge clk);
        n_cmp++; if (f_if.ovf !== 1'b1) begin n_fail++; $display("FAIL wrap.ovf_sticky: got %0d expected 1", f_if.ovf); end
        n_cmp++; if (f_if.frac !== 7'd1) begin n_fail++; $display("FAIL wrap.post_frac: got %0d expected 1", f_if.frac); end
        f_if.clear = 1'b1;
        @(negedge clk);
        f_if.clear = 1'b0;
        n_cmp++; if (f_if.ovf !== 1'b0) begin n_fail++; $display("FAIL wrap.ovf_clear: got %0d expected 0", f_if.ovf); end
    endtask

    task automatic test_clear_wins();
        int ticks;
        ticks = 0;
        sw_if.clear = 1'b1;
        sw_if.start_stop = 1'b1;
        @(negedge clk);
        sw_if.clear = 1'b0;
        sw_if.start_stop = 1'b0;
        n_cmp++; if (sw_if.running !== 1'b0) begin n_fail++; $display("FAIL clear.running: got %0d expected 0", sw_if.running); end
        n_cmp++; if ({sw_if.min, sw_if.sec, sw_if.frac} !== 14'd0) begin n_fail++; $display("FAIL clear.fields: got %0d:%0d.%0d expected 0:0.0", sw_if.min, sw_if.sec, sw_if.frac); end
        n_cmp++; if (sw_if.ovf !== 1'b0) begin n_fail++; $display("FAIL clear.ovf: got %0d expected 0", sw_if.ovf); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sw_if.tick) ticks++;
        end
        n_cmp++; if (ticks != 0) begin n_fail++; $display("FAIL clear.idle_ticks: got %0d expected 0", ticks); end
    endtask

    task automatic test_lap();
        sw_if.start_stop = 1'b1;
        @(negedge clk);
        sw_if.start_stop = 1'b0;
        repeat (419) @(negedge clk);
        n_cmp++; if (sw_if.frac !== 7'd41) begin n_fail++; $display("FAIL lap.pre_frac: got %0d expected 41", sw_if.frac); end
        sw_if.lap = 1'b1;
        @(negedge clk);
        sw_if.lap = 1'b0;
        n_cmp++; if (sw_if.frac !== 7'd42) begin n_fail++; $display("FAIL lap.frac: got %0d expected 42", sw_if.frac); end
`ifdef STOPWATCH_LAP_EN
        n_cmp++; if (sw_if.lap_frac !== 7'd41) begin n_fail++; $display("FAIL lap.lap_frac: got %0d expected 41", sw_if.lap_frac); end
        n_cmp++; if (sw_if.lap_valid !== 1'b1) begin n_fail++; $display("FAIL lap.lap_valid: got %0d expected 1", sw_if.lap_valid); end
`else
        n_cmp++; if (sw_if.lap_frac !== 7'd0) begin n_fail++; $display("FAIL lap.lap_frac: got %0d expected 0", sw_if.lap_frac); end
        n_cmp++; if (sw_if.lap_valid !== 1'b0) begin n_fail++; $display("FAIL lap.lap_valid: got %0d expected 0", sw_if.lap_valid); end
`endif
        n_cmp++; if ({sw_if.lap_min, sw_if.lap_sec} !== 7'd0) begin n_fail++; $display("FAIL lap.lap_min_sec: got %0d:%0d expected 0:0", sw_if.lap_min, sw_if.lap_sec); end
        sw_if.clear = 1'b1;
        @(negedge clk);
        sw_if.clear = 1'b0;
        n_cmp++; if ({sw_if.lap_valid, sw_if.lap_frac} !== 8'd0) begin n_fail++; $display("FAIL lap.clear: got valid=%0d frac=%0d expected 0", sw_if.lap_valid, sw_if.lap_frac); end
    endtask

    task automatic test_async_reset();
        int ticks;
        ticks = 0;
        sw_if.start_stop = 1'b1;
        @(negedge clk);
        sw_if.start_stop = 1'b0;
        repeat (70) @(negedge clk);
        n_cmp++; if (sw_if.frac !== 7'd7) begin n_fail++; $display("FAIL arst.pre_frac: got %0d expected 7", sw_if.frac); end
        #2;
        n_rst = 1'b1;
        #1;
        n_cmp++; if (sw_if.frac !== 7'd0) begin n_fail++; $display("FAIL arst.frac: got %0d expected 0", sw_if.frac); end
        n_cmp++; if (sw_if.running !== 1'b0) begin n_fail++; $display("FAIL arst.running: got %0d expected 0", sw_if.running); end
        @(negedge clk);
        n_rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sw_if.tick) ticks++;
        end
        n_cmp++; if (ticks != 0) begin n_fail++; $display("FAIL arst.ticks_after: got %0d expected 0", ticks); end
        n_cmp++; if (sw_if.running !== 1'b0) begin n_fail++; $display("FAIL arst.running_after: got %0d expected 0", sw_if.running); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_run();
        test_pause_resume();
        test_clear_wins();
        test_wrap();
        test_lap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
